// File: rtl/axi_port_arbiter_if.sv
// AXI4 master-port bundle (AW/W/B/AR/R) shared by the image-pipeline requesters.
// The arbiter takes the master modport; the DDR controller side takes the slave modport.
interface axi_port_arbiter_if #(
  parameter int DW  = 128,
  parameter int IDW = 4
);
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [IDW-1:0]  awid;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic [IDW-1:0]  bid;
  logic            bvalid;
  logic            bready;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [IDW-1:0]  arid;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awlen, awid, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arid, arvalid, rready,
    input  awready, wready, bresp, bid, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awlen, awid, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arid, arvalid, rready,
    output awready, wready, bresp, bid, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_port_arbiter.sv
// Round-robin arbiter sharing one AXI4 master port between NUM_REQ burst requesters.
// One burst is in flight at a time; the AXI ID carries the winning requester index.
module axi_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DW      = 128,
  parameter int IDW     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [4*NUM_REQ-1:0]    req_len,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_err,
  input  logic [DW*NUM_REQ-1:0]   u_wdata,
  input  logic [NUM_REQ-1:0]      u_wvalid,
  output logic [NUM_REQ-1:0]      u_wready,
  output logic [DW-1:0]           u_rdata,
  output logic [NUM_REQ-1:0]      u_rvalid,
  input  logic [NUM_REQ-1:0]      u_rready,
  axi_port_arbiter_if.master      axi
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

  state_t             state, state_next;
  logic [PW-1:0]      ptr, winner, sel, winner_inc;
  logic               found;
  logic [31:0]        addr_q;
  logic [3:0]         len_q, beat_cnt;
  logic               err;
  logic [NUM_REQ-1:0] done_q, err_q, winner_oh;
  logic               last_beat, w_hs, r_hs, r_beat_err, b_err;

  // Round-robin scan starting at the pointer; the first pending requester wins.
  always_comb begin
    int s;
    s     = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = int'(ptr) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!found && req_valid[PW'(s)]) begin
        found = 1'b1;
        sel   = PW'(s);
      end
    end
  end

  always_comb begin
    winner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) winner_oh[i] = (winner == PW'(i));
  end

  assign winner_inc = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign last_beat  = (beat_cnt == len_q);

  assign axi.awvalid = (state == AW);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awid    = IDW'(winner);
  assign axi.wvalid  = (state == W) && u_wvalid[winner];
  assign axi.wdata   = (state == W) ? u_wdata[winner*DW +: DW] : '0;
  assign axi.wstrb   = (state == W) ? '1 : '0;
  assign axi.wlast   = (state == W) && last_beat;
  assign axi.bready  = (state == B);
  assign axi.arvalid = (state == AR);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arid    = IDW'(winner);
  assign axi.rready  = (state == R) && u_rready[winner];

  assign w_hs       = axi.wvalid && axi.wready;
  assign r_hs       = axi.rvalid && axi.rready;
  assign r_beat_err = (axi.rresp != 2'b00) || (axi.rlast != last_beat);
  assign b_err      = (axi.bresp != 2'b00) || (axi.bid != IDW'(winner));

  assign u_wready  = (state == W && axi.wready) ? winner_oh : '0;
  assign u_rvalid  = (state == R && axi.rvalid) ? winner_oh : '0;
  assign u_rdata   = (state == R) ? axi.rdata : '0;
  assign req_grant = (state != IDLE) ? winner_oh : '0;
  assign req_done  = done_q;
  assign req_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = req_write[sel] ? AW : AR;
      AW:      if (axi.awready) state_next = W;
      W:       if (w_hs && last_beat) state_next = B;
      B:       if (axi.bvalid) state_next = IDLE;
      AR:      if (axi.arready) state_next = R;
      R:       if (r_hs && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Completion is registered, so the done pulse lands in the next IDLE sampling cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      winner   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: if (found) begin
          winner   <= sel;
          addr_q   <= req_addr[sel*32 +: 32];
          len_q    <= req_len[sel*4 +: 4];
          beat_cnt <= '0;
          err      <= 1'b0;
        end
        W: if (w_hs) beat_cnt <= beat_cnt + 4'd1;
        B: if (axi.bvalid) begin
          done_q <= winner_oh;
          err_q  <= winner_oh & {NUM_REQ{b_err}};
          ptr    <= winner_inc;
        end
        R: if (r_hs) begin
          beat_cnt <= beat_cnt + 4'd1;
          err      <= err | r_beat_err;
          if (last_beat) begin
            done_q <= winner_oh;
            err_q  <= winner_oh & {NUM_REQ{err | r_beat_err}};
            ptr    <= winner_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_port_arbiter.sv
// Directed self-checking bench for axi_port_arbiter: the bench plays the DDR-side AXI slave
// and the requesters, and compares every output against hand-derived values.
module tb_axi_port_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DW      = 128;
  localparam int IDW     = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid, req_write, req_grant, req_done, req_err;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [4*NUM_REQ-1:0]  req_len;
  logic [DW*NUM_REQ-1:0] u_wdata;
  logic [NUM_REQ-1:0]    u_wvalid, u_wready, u_rvalid, u_rready;
  logic [DW-1:0]         u_rdata;
  int                    checks = 0;
  int                    failures = 0;

  axi_port_arbiter_if #(.DW(DW), .IDW(IDW)) axi();

  axi_port_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
    .u_wdata(u_wdata), .u_wvalid(u_wvalid), .u_wready(u_wready),
    .u_rdata(u_rdata), .u_rvalid(u_rvalid), .u_rready(u_rready),
    .axi(axi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  function automatic logic [DW-1:0] beatData(input int idx, input int b);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(idx * 256 + b);
    return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input bit valid, input bit write,
                               input logic [31:0] addr, input logic [3:0] len);
    req_valid[idx]        = valid;
    req_write[idx]        = write;
    req_addr[idx*32 +: 32] = addr;
    req_len[idx*4 +: 4]    = len;
  endtask

  task automatic fillWdata(input int b);
    for (int j = 0; j < NUM_REQ; j++) u_wdata[j*DW +: DW] = beatData(j, b);
  endtask

  // Starts at a negedge just before the IDLE sampling edge; returns on the done cycle.
  task automatic doWrite(input int idx, input logic [31:0] addr, input int len, input int awDelay,
                         input int stallBeat, input int stallCyc, input logic [1:0] bresp,
                         input logic [3:0] bidv, input bit expErr, input bit dropReq);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    u_wvalid = '1;
    fillWdata(0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("aw_grant", req_grant, oh);
    checkOutput("aw_done_clear", req_done, 0);
    checkOutput("awvalid", axi.awvalid, 1);
    checkOutput("awid", axi.awid, idx);
    checkOutput("awaddr", axi.awaddr, addr);
    checkOutput("awlen", axi.awlen, len);
    checkOutput("w_before_aw", axi.wvalid, 0);
    if (dropReq) req_valid[idx] = 1'b0;
    for (int c = 0; c < awDelay; c++) begin
      axi.awready = 1'b0;
      @(negedge clk);
      checkOutput("awvalid_hold", axi.awvalid, 1);
      checkOutput("awaddr_hold", axi.awaddr, addr);
    end
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0;
    checkOutput("awvalid_off", axi.awvalid, 0);
    for (int b = 0; b <= len; b++) begin
      fillWdata(b);
      if (b == stallBeat) begin
        for (int s = 0; s < stallCyc; s++) begin
          axi.wready = 1'b0;
          #1;
          checkOutput("stall_wdata", axi.wdata, beatData(idx, b));
          checkOutput("stall_wlast", axi.wlast, b == len);
          checkOutput("stall_uwready", u_wready, 0);
          @(negedge clk);
        end
      end
      axi.wready = 1'b1;
      #1;
      checkOutput("wvalid", axi.wvalid, 1);
      checkOutput("wdata", axi.wdata, beatData(idx, b));
      checkOutput("wlast", axi.wlast, b == len);
      checkOutput("uwready", u_wready, oh);
      @(negedge clk);
    end
    axi.wready = 1'b0;
    u_wvalid   = '0;
    #1;
    checkOutput("bready", axi.bready, 1);
    checkOutput("wvalid_off", axi.wvalid, 0);
    axi.bvalid = 1'b1;
    axi.bresp  = bresp;
    axi.bid    = bidv;
    @(negedge clk);
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    axi.bid    = '0;
    #1;
    checkOutput("w_done", req_done, oh);
    checkOutput("w_err", req_err, expErr ? oh : '0);
    checkOutput("w_grant_off", req_grant, 0);
  endtask

  task automatic doRead(input int idx, input logic [31:0] addr, input int len, input bit throttle,
                        input int rrespBeat, input int rlastBeat, input bit expErr, input bit dropReq);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ar_grant", req_grant, oh);
    checkOutput("ar_done_clear", req_done, 0);
    checkOutput("arvalid", axi.arvalid, 1);
    checkOutput("arid", axi.arid, idx);
    checkOutput("araddr", axi.araddr, addr);
    checkOutput("arlen", axi.arlen, len);
    checkOutput("ar_no_awvalid", axi.awvalid, 0);
    if (dropReq) req_valid[idx] = 1'b0;
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    checkOutput("arvalid_off", axi.arvalid, 0);
    for (int b = 0; b <= len; b++) begin
      if (throttle) begin
        axi.rvalid = 1'b0;
        #1;
        checkOutput("r_gap_urvalid", u_rvalid, 0);
        @(negedge clk);
      end
      axi.rvalid = 1'b1;
      axi.rdata  = beatData(idx + 4, b);
      axi.rresp  = (b == rrespBeat) ? 2'b10 : 2'b00;
      axi.rlast  = (b == rlastBeat);
      #1;
      checkOutput("urvalid", u_rvalid, oh);
      checkOutput("urdata", u_rdata, beatData(idx + 4, b));
      checkOutput("rready", axi.rready, 1);
      @(negedge clk);
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
    #1;
    checkOutput("r_done", req_done, oh);
    checkOutput("r_err", req_err, expErr ? oh : '0);
    checkOutput("r_grant_off", req_grant, 0);
    checkOutput("rready_off", axi.rready, 0);
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 0, 1};
    reset = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
    u_wdata = '0; u_wvalid = '0; u_rready = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bresp = 2'b00; axi.bid = '0; axi.bvalid = 1'b0;
    axi.arready = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    #1;
    checkOutput("rst_awvalid", axi.awvalid, 0);
    checkOutput("rst_arvalid", axi.arvalid, 0);
    checkOutput("rst_bready", axi.bready, 0);
    checkOutput("rst_rready", axi.rready, 0);
    checkOutput("rst_grant", req_grant, 0);
    checkOutput("rst_done", req_done, 0);
    checkOutput("rst_err", req_err, 0);
    checkOutput("rst_uwready", u_wready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("[TB] single write, requester 1, awready delayed");
    applyStimulus(1, 1, 1, 32'h0000_1000, 4'd3);
    doWrite(1, 32'h0000_1000, 3, 2, -1, 0, 2'b00, 4'd1, 1'b0, 1'b1);

    $display("[TB] throttled read, requester 0");
    applyStimulus(0, 1, 0, 32'h0000_2000, 4'd7);
    u_rready = '1;
    doRead(0, 32'h0000_2000, 7, 1'b1, -1, 7, 1'b0, 1'b1);

    $display("[TB] error responses");
    applyStimulus(2, 1, 0, 32'h0000_4000, 4'd3);
    doRead(2, 32'h0000_4000, 3, 1'b0, 1, 3, 1'b1, 1'b1);
    applyStimulus(2, 1, 0, 32'h0000_4100, 4'd3);
    doRead(2, 32'h0000_4100, 3, 1'b0, -1, 2, 1'b1, 1'b1);
    applyStimulus(2, 1, 1, 32'h0000_4200, 4'd0);
    doWrite(2, 32'h0000_4200, 0, 0, -1, 0, 2'b00, 4'd0, 1'b1, 1'b1);
    applyStimulus(1, 1, 1, 32'h0000_4300, 4'd1);
    doWrite(1, 32'h0000_4300, 1, 0, -1, 0, 2'b10, 4'd1, 1'b1, 1'b1);

    $display("[TB] write stalled by wready");
    applyStimulus(0, 1, 1, 32'h0000_5000, 4'd3);
    doWrite(0, 32'h0000_5000, 3, 0, 1, 5, 2'b00, 4'd0, 1'b0, 1'b1);

    $display("[TB] reset in the middle of a read burst");
    applyStimulus(1, 1, 0, 32'h0000_3000, 4'd7);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_ar_grant", req_grant, 3'b010);
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    applyStimulus(0, 1, 1, 32'h0000_6000, 4'd0);
    applyStimulus(1, 1, 0, 32'h0000_6100, 4'd1);
    applyStimulus(2, 1, 1, 32'h0000_6200, 4'd0);
    for (int b = 0; b < 2; b++) begin
      axi.rvalid = 1'b1;
      axi.rlast  = 1'b0;
      #1;
      checkOutput("mid_urvalid", u_rvalid, 3'b010);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_awvalid", axi.awvalid, 0);
    checkOutput("mid_rst_arvalid", axi.arvalid, 0);
    checkOutput("mid_rst_rready", axi.rready, 0);
    checkOutput("mid_rst_grant", req_grant, 0);
    checkOutput("mid_rst_done", req_done, 0);
    checkOutput("mid_rst_urvalid", u_rvalid, 0);
    @(negedge clk);
    axi.rvalid = 1'b0;
    reset = 1'b1;

    $display("[TB] all requesters pending, round-robin from pointer 0");
    foreach (order[k]) begin
      if (order[k] == 1)
        doRead(1, 32'h0000_6100, 1, 1'b0, -1, 1, 1'b0, 1'b0);
      else
        doWrite(order[k], 32'h0000_6000 + 32'(order[k] * 256), 0, 0, -1, 0, 2'b00,
                4'(order[k]), 1'b0, 1'b0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_port_arbiter.md
Name: axi_port_arbiter

Overview:
- Shares one AXI4 master port (DDR controller side, 128-bit data) between NUM_REQ image-pipeline requesters (camera writer, recognition reader, display reader, etc.).
- Each requester posts a single read or write burst command. The arbiter grants round-robin, drives the AW/W/B or AR/R channels, steers data to/from the winner and pulses done.
- One transaction is outstanding at a time; the next grant is issued only after the current one completes.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
DW, 128, AXI data width in bits
IDW, 4, AXI ID width; ID carries the requester index

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  command request per requester; held until grant
req_write  in  NUM_REQ  1=write burst, 0=read burst
req_addr  in  32*NUM_REQ  burst start address, slice i for requester i
req_len  in  4*NUM_REQ  beats minus 1 (0..15)
req_grant  out  NUM_REQ  one-hot, high from grant until done
req_done  out  NUM_REQ  one-cycle completion pulse
req_err  out  NUM_REQ  valid with req_done; 1 = error response or rlast mismatch
u_wdata  in  DW*NUM_REQ  write data per requester
u_wvalid  in  NUM_REQ  write beat valid
u_wready  out  NUM_REQ  write beat accepted (granted requester only)
u_rdata  out  DW  read data, broadcast
u_rvalid  out  NUM_REQ  read beat valid (granted requester only)
u_rready  in  NUM_REQ  read beat ready
awaddr/awlen/awid/awvalid  out  32/4/IDW/1  write address channel
awready  in  1
wdata/wstrb/wlast/wvalid  out  DW/DW/8/1/1  write data channel; wstrb all ones
wready  in  1
bresp/bid/bvalid  in  2/IDW/1; bready out 1
araddr/arlen/arid/arvalid  out  32/4/IDW/1; arready in 1
rdata/rresp/rlast/rvalid  in  DW/2/1/1; rready out 1

Behaviour:
- Reset: all outputs 0, including AXI valids, bready, rready, grants, done, err and u_* outputs. FSM goes to IDLE. Priority pointer goes to 0 and beat counter to 0. Reset asserted mid-burst abandons the transaction immediately.
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE:
  - Scan req_valid starting at the pointer, wrapping modulo NUM_REQ. The first set bit wins.
  - Register the winner's addr, len and write flag, and set req_grant.
  - Go to AW if write, AR if read. No request: stay in IDLE.
- AW: awvalid=1 from the cycle after the request is sampled. awid=winner index. Hold all fields stable until awready. On handshake go to W.
- W:
  - wvalid = u_wvalid[winner]; wdata = winner slice; u_wready[winner] = wready.
  - A beat completes on wvalid&wready, and beat_cnt increments.
  - wlast=1 when beat_cnt==len. After the last beat go to B.
- B: bready=1. On bvalid, latch err = (bresp!=0) | (bid!=winner), then complete.
- AR: arvalid=1 and arid=winner. Hold stable until arready, then go to R.
- R:
  - rready = u_rready[winner]; u_rvalid[winner] = rvalid; u_rdata = rdata.
  - Each beat handshake increments beat_cnt and ORs (rresp!=0) into the sticky err.
  - rlast on a beat other than beat len, or beat len without rlast, sets err.
  - Complete after beat len, regardless of rlast.
- Complete:
  - req_done[winner]=1 and req_err[winner]=err for exactly one cycle.
  - req_grant drops in the same cycle. The pointer becomes winner+1 (wrapping) and the FSM returns to IDLE.
  - The minimum gap between the done pulse and the next awvalid/arvalid is 1 cycle (the IDLE sampling cycle).
- Single-beat bursts (len=0): wlast is high on the first beat.
- Requests from non-granted requesters are ignored (no u_wready/u_rvalid) and held pending.
- req_valid dropping after grant does not abort the transaction.
- Simultaneous requests: winner is chosen by round-robin from the pointer; no requester waits more than NUM_REQ-1 transactions.
- The AW and W channels are sequential; W never starts before the AW handshake.

Test Plan:
- Single write, req 1, addr 0x1000, len 3, awready after 2 cycles, wready always 1 -> awid=1, 4 W beats with wlast on beat 4, bresp=0 -> req_done[1] pulse, err=0.
- Read, req 0, len 7, rvalid throttled every other cycle, u_rready=1 -> 8 beats to u_rdata, rlast on beat 8 -> done[0], err=0, pointer=1.
- All 3 requesting continuously -> grants in order 0,1,2,0,1, each grant followed by the next after exactly a 1-cycle IDLE gap.
- Read with rresp=2 on beat 2 of 4 -> all 4 beats transferred, done[x] with err=1; rlast asserted early on beat 3 of 4 -> err=1.
- Write stalled by wready=0 for 5 cycles on beat 2 -> wdata and wlast stable, beat_cnt frozen, completion after the stall.
- Reset pulled low mid-R burst -> awvalid, arvalid, rready, grants and done all 0 immediately; after release, pointer=0 and the pending request is granted fresh.
